ipv4_hdr_builder: RTL and testbench

//  Builds a 20-byte IPv4 header (no options) from latched fields and sizes it for the TCP/IP checksum engine.

---
 rtl/ip_pkg.sv | 20 ++
 rtl/ipv4_hdr_word_mux.sv | 34 +++
 rtl/ipv4_hdr_builder.sv | 208 ++++++++++++++++++++
 tb/tb_ipv4_hdr_builder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
`timescale 1ns/1ps
// Shared IPv4 definitions for the TX header path: fixed header constants,
// protocol numbers and the header builder state encoding.
package ip_pkg;
  localparam logic [7:0] IPV4_VER_IHL = 8'h45;
  localparam logic [7:0] IP_PROTO_TCP = 8'd6;
  localparam logic [7:0] IP_PROTO_UDP = 8'd17;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    EMIT = 3'd4,
    DONE = 3'd5
  } hdr_state_t;
endpackage

// File: rtl/ipv4_hdr_word_mux.sv
`timescale 1ns/1ps
// Selects one 32-bit word of a 20-byte option-less IPv4 header from the
// latched fields; the checksum slot is whatever the caller supplies.
module ipv4_hdr_word_mux
  import ip_pkg::*;
#(
  parameter logic [7:0] TOS    = 8'h00,
  parameter logic       DF_BIT = 1'b1
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      total_len,
  input  logic [15:0]      ident,
  input  logic [7:0]       ttl,
  input  logic [7:0]       protocol,
  input  logic [31:0]      src_ip,
  input  logic [31:0]      dst_ip,
  input  logic [15:0]      csum,
  output logic [31:0]      word
);

  // Word select, big-endian word order W0..W4.
  always_comb begin
    word = 32'h0000_0000;
    case (idx)
      3'd0:    word = {IPV4_VER_IHL, TOS, total_len};
      3'd1:    word = {ident, 1'b0, DF_BIT, 1'b0, 13'd0};
      3'd2:    word = {ttl, protocol, csum};
      3'd3:    word = src_ip;
      3'd4:    word = dst_ip;
      default: word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ipv4_hdr_builder.sv
`timescale 1ns/1ps
// Builds an IPv4 header, runs it through the external checksum engine with a
// zero checksum field, then emits the finished header on a valid/ready stream.
module ipv4_hdr_builder
  import ip_pkg::*;
#(
  parameter logic [7:0] TOS          = 8'h00,
  parameter logic       DF_BIT       = 1'b1,
  parameter int         WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] total_len,
  input  logic [15:0] ident,
  input  logic [7:0]  ttl,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic        busy,
  output logic [31:0] ck_data,
  output logic        ck_vld,
  output logic        ck_last,
  input  logic [15:0] ck_sum,
  input  logic        ck_sum_vld,
  output logic        ck_sum_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_TIMEOUT - 1);

  hdr_state_t       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [15:0]      cnt_r;
  logic [15:0]      total_len_r;
  logic [15:0]      ident_r;
  logic [7:0]       ttl_r;
  logic [7:0]       protocol_r;
  logic [31:0]      src_ip_r;
  logic [31:0]      dst_ip_r;
  logic [15:0]      csum_r;
  logic             error_r;
  logic [31:0]      ck_data_r;
  logic             ck_vld_r;
  logic             ck_last_r;
  logic [31:0]      m_data_r;
  logic             m_valid_r;
  logic             m_last_r;
  logic             done_r;

  logic [IDX_W-1:0] mux_idx_s;
  logic [15:0]      mux_csum_s;
  logic [31:0]      mux_word_s;

  // Word to load into the output registers on the next edge; the mux always
  // looks one word ahead so that ck_data and m_data leave flops directly.
  always_comb begin
    mux_idx_s  = idx_r + 3'd1;
    mux_csum_s = 16'h0000;
    case (state_r)
      CLR: begin
        mux_idx_s  = 3'd0;
        mux_csum_s = 16'h0000;
      end
      WAIT: begin
        mux_idx_s  = 3'd0;
        mux_csum_s = ck_sum;
      end
      EMIT: begin
        mux_idx_s  = idx_r + 3'd1;
        mux_csum_s = csum_r;
      end
      default: begin
        mux_idx_s  = idx_r + 3'd1;
        mux_csum_s = 16'h0000;
      end
    endcase
  end

  ipv4_hdr_word_mux #(
    .TOS    (TOS),
    .DF_BIT (DF_BIT)
  ) u_word_mux (
    .idx       (mux_idx_s),
    .total_len (total_len_r),
    .ident     (ident_r),
    .ttl       (ttl_r),
    .protocol  (protocol_r),
    .src_ip    (src_ip_r),
    .dst_ip    (dst_ip_r),
    .csum      (mux_csum_s),
    .word      (mux_word_s)
  );

  // Header sequencing FSM with registered stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      cnt_r       <= 16'h0000;
      total_len_r <= 16'h0000;
      ident_r     <= 16'h0000;
      ttl_r       <= 8'h00;
      protocol_r  <= 8'h00;
      src_ip_r    <= 32'h0000_0000;
      dst_ip_r    <= 32'h0000_0000;
      csum_r      <= 16'h0000;
      error_r     <= 1'b0;
      ck_data_r   <= 32'h0000_0000;
      ck_vld_r    <= 1'b0;
      ck_last_r   <= 1'b0;
      m_data_r    <= 32'h0000_0000;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            total_len_r <= total_len;
            ident_r     <= ident;
            ttl_r       <= ttl;
            protocol_r  <= protocol;
            src_ip_r    <= src_ip;
            dst_ip_r    <= dst_ip;
            error_r     <= 1'b0;
            state_r     <= CLR;
          end
        end
        CLR: begin
          idx_r     <= 3'd0;
          ck_data_r <= mux_word_s;
          ck_vld_r  <= 1'b1;
          ck_last_r <= 1'b0;
          state_r   <= FEED;
        end
        FEED: begin
          if (idx_r == LAST_IDX) begin
            ck_data_r <= 32'h0000_0000;
            ck_vld_r  <= 1'b0;
            ck_last_r <= 1'b0;
            cnt_r     <= 16'h0000;
            state_r   <= WAIT;
          end else begin
            idx_r     <= mux_idx_s;
            ck_data_r <= mux_word_s;
            ck_last_r <= (mux_idx_s == LAST_IDX);
          end
        end
        WAIT: begin
          if (ck_sum_vld) begin
            csum_r    <= ck_sum;
            idx_r     <= 3'd0;
            m_data_r  <= mux_word_s;
            m_valid_r <= 1'b1;
            m_last_r  <= 1'b0;
            state_r   <= EMIT;
          end else if (cnt_r == TIMEOUT_LAST) begin
            error_r <= 1'b1;
            state_r <= IDLE;
          end else if (cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        EMIT: begin
          if (m_ready) begin
            if (idx_r == LAST_IDX) begin
              m_data_r  <= 32'h0000_0000;
              m_valid_r <= 1'b0;
              m_last_r  <= 1'b0;
              done_r    <= 1'b1;
              state_r   <= DONE;
            end else begin
              idx_r    <= mux_idx_s;
              m_data_r <= mux_word_s;
              m_last_r <= (mux_idx_s == LAST_IDX);
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          idx_r   <= 3'd0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_r != IDLE);
  assign ck_sum_ready = (state_r == CLR) || ((state_r == WAIT) && ck_sum_vld);
  assign ck_data      = ck_data_r;
  assign ck_vld       = ck_vld_r;
  assign ck_last      = ck_last_r;
  assign m_data       = m_data_r;
  assign m_valid      = m_valid_r;
  assign m_last       = m_last_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: tb/tb_ipv4_hdr_builder.sv
`timescale 1ns/1ps
// Bench for ipv4_hdr_builder: a behavioural checksum engine plus a byte-level
// IPv4 header reference model, directed and randomized headers.
module tb_ipv4_hdr_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] total_len = 16'h0000;
  logic [15:0] ident = 16'h0000;
  logic [7:0]  ttl = 8'h00;
  logic [7:0]  protocol = 8'h00;
  logic [31:0] src_ip = 32'h0;
  logic [31:0] dst_ip = 32'h0;
  logic        busy;
  logic [31:0] ck_data;
  logic        ck_vld;
  logic        ck_last;
  logic [15:0] ck_sum;
  logic        ck_sum_vld;
  logic        ck_sum_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] f_total_len;
  logic [15:0] f_ident;
  logic [7:0]  f_ttl;
  logic [7:0]  f_proto;
  logic [31:0] f_src;
  logic [31:0] f_dst;
  logic [31:0] exp_w [5];

  logic        stub_en = 1'b1;
  logic [15:0] eng_acc;

  always #5 clk = ~clk;

  ipv4_hdr_builder #(
    .TOS          (8'h00),
    .DF_BIT       (1'b1),
    .WAIT_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .total_len    (total_len),
    .ident        (ident),
    .ttl          (ttl),
    .protocol     (protocol),
    .src_ip       (src_ip),
    .dst_ip       (dst_ip),
    .busy         (busy),
    .ck_data      (ck_data),
    .ck_vld       (ck_vld),
    .ck_last      (ck_last),
    .ck_sum       (ck_sum),
    .ck_sum_vld   (ck_sum_vld),
    .ck_sum_ready (ck_sum_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .done         (done),
    .error        (error)
  );

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Checksum engine stand-in: accumulates fed words, result valid one cycle after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_acc    <= 16'h0000;
      ck_sum_vld <= 1'b0;
    end else if (ck_sum_ready) begin
      eng_acc    <= 16'h0000;
      ck_sum_vld <= 1'b0;
    end else if (ck_vld) begin
      eng_acc <= oc_add(oc_add(eng_acc, ck_data[31:16]), ck_data[15:0]);
      if (ck_last && stub_en) ck_sum_vld <= 1'b1;
    end
  end
  assign ck_sum = ~eng_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference header: 20 bytes laid out from the field rules, checksum over ten 16-bit words.
  task automatic compute_expected();
    logic [7:0]  b [20];
    int unsigned s;
    logic [15:0] c;
    b[0]  = 8'h45;            b[1]  = 8'h00;
    b[2]  = f_total_len[15:8]; b[3] = f_total_len[7:0];
    b[4]  = f_ident[15:8];    b[5]  = f_ident[7:0];
    b[6]  = 8'h40;            b[7]  = 8'h00;
    b[8]  = f_ttl;            b[9]  = f_proto;
    b[10] = 8'h00;            b[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[12 + i] = f_src[31 - 8 * i -: 8];
      b[16 + i] = f_dst[31 - 8 * i -: 8];
    end
    s = 0;
    for (int i = 0; i < 10; i++) s = s + 32'({b[2 * i], b[2 * i + 1]});
    while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
    c = ~s[15:0];
    b[10] = c[15:8];
    b[11] = c[7:0];
    for (int i = 0; i < 5; i++) exp_w[i] = {b[4 * i], b[4 * i + 1], b[4 * i + 2], b[4 * i + 3]};
  endtask

  task automatic set_case1();
    f_total_len = 16'h0073; f_ident = 16'h0000; f_ttl = 8'h40; f_proto = 8'h11;
    f_src = 32'hc0a8_0001;  f_dst = 32'hc0a8_00c7;
  endtask

  task automatic set_random();
    f_total_len = 16'($urandom); f_ident = 16'($urandom); f_ttl = 8'($urandom);
    f_proto = ($urandom_range(0, 1) == 0) ? 8'd6 : 8'd17;
    f_src = $urandom; f_dst = $urandom;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, busy, ck_vld, ck_last, ck_sum_ready, m_valid, m_last, done, error}, 32'd0);
    chk({tag, "_ck_data"}, ck_data, 32'd0);
    chk({tag, "_m_data"}, m_data, 32'd0);
  endtask

  // Present fields and pulse start across edge 0; fields are scrambled afterwards.
  task automatic launch();
    @(negedge clk);
    total_len = f_total_len; ident = f_ident; ttl = f_ttl; protocol = f_proto;
    src_ip = f_src; dst_ip = f_dst; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_len = 16'($urandom); ident = 16'($urandom); ttl = 8'($urandom);
    protocol = 8'($urandom); src_ip = $urandom; dst_ip = $urandom;
  endtask

  // One full header; mode 0: ready high, 1: ready 1,0,0 pattern, 2: random ready.
  task automatic run_header(input int mode, input bit poke);
    int   cyc;
    int   beat;
    int   vcnt;
    int   ckb;
    bit   seen;
    logic rdy;
    compute_expected();
    launch();
    cyc = 1; beat = 0; vcnt = 0; ckb = 0; seen = 1'b0;
    while (beat < 5 && cyc < 200) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("error_cleared", {31'd0, error}, 32'd0);
        chk("clr_ready", {31'd0, ck_sum_ready}, 32'd1);
      end
      if (cyc == 2) chk("clr_one_cycle", {31'd0, ck_sum_ready}, 32'd0);
      if (ck_vld) begin
        ckb++;
        chk("ck_last", {31'd0, ck_last}, 32'(ckb == 5));
      end
      start = poke && (cyc == 9);
      if (m_valid) begin
        if (!seen) begin
          chk("first_valid_cycle", 32'(cyc), 32'd8);
          seen = 1'b1;
        end
        chk("m_data", m_data, exp_w[beat]);
        chk("m_last", {31'd0, m_last}, 32'(beat == 4));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ((vcnt % 3) == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        vcnt++;
        m_ready = rdy;
        if (rdy) begin
          if (beat == 4 && mode == 0) chk("w4_cycle", 32'(cyc), 32'd12);
          beat++;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    if (beat < 5) chk("emit_bound", 32'(beat), 32'd5);
    chk("ck_beats", 32'(ckb), 32'd5);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("valid_after_last", {31'd0, m_valid}, 32'd0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  vflag;
    bit  bdone;

    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("idle");

    // Case 1: reference header with ready held high.
    set_case1();
    compute_expected();
    chk("ref_w2", exp_w[2], 32'h4011_b861);
    run_header(0, 1'b0);

    // Case 2: ready 1,0,0 stall pattern.
    set_case1();
    run_header(1, 1'b0);

    // Case 3: start pulses during EMIT and DONE are ignored; back-to-back header follows.
    set_random();
    run_header(2, 1'b1);
    set_random();
    run_header(0, 1'b0);

    // Case 4: engine never answers -> timeout error, no output beats.
    stub_en = 1'b0;
    set_case1();
    launch();
    cyc = 1; vflag = 1'b0; bdone = 1'b0;
    while (!bdone && cyc < 100) begin
      @(negedge clk);
      if (m_valid) vflag = 1'b1;
      if (!busy) bdone = 1'b1;
      else cyc++;
    end
    chk("timeout_idle_cycle", 32'(cyc), 32'd23);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_no_valid", {31'd0, vflag}, 32'd0);
    repeat (3) @(negedge clk);
    chk("error_sticky", {31'd0, error}, 32'd1);
    stub_en = 1'b1;
    run_header(0, 1'b0);

    // Case 5: reset while feeding word 2, then a clean header.
    set_case1();
    compute_expected();
    launch();
    repeat (4) @(negedge clk);
    chk("feed_idx2_vld", {31'd0, ck_vld}, 32'd1);
    chk("feed_idx2_data", ck_data, exp_w[2] & 32'hFFFF_0000);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    set_case1();
    run_header(0, 1'b0);

    // Case 6: all-ones fields force end-around carries.
    f_total_len = 16'hFFFF; f_ident = 16'hFFFF; f_ttl = 8'hFF; f_proto = 8'h06;
    f_src = 32'hFFFF_FFFF; f_dst = 32'hFFFF_FFFF;
    run_header(1, 1'b0);

    // Randomized headers with random backpressure.
    for (int n = 0; n < 6; n++) begin
      set_random();
      run_header(2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
